// File: rtl/jfpjc_pkg.sv
// Shared definitions for the jfpjc output framer: FSM states, JPEG marker
// bytes and a width helper for small address buses.
package jfpjc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_EOI_FF,
    S_EOI_D9
  } state_t;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] EOI           = 8'hD9;
  localparam logic [7:0] STUFF         = 8'h00;

  // Address width that stays at least one bit for single-entry memories.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/jfif_header_ram.sv
// Header byte store: one write port, one registered read port.
module jfif_header_ram #(
  parameter int DEPTH = 328,
  parameter int AW    = 9
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;

  // Write and synchronous read; contents survive reset on purpose.
  always_ff @(posedge clock) begin
    if (i_we && (i_waddr <= AW'(DEPTH - 1))) r_mem[i_waddr] <= i_wdata;
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/jfif_stream_framer.sv
// JFIF byte-stream framer: header from RAM, byte-stuffed scan data, EOI.
module jfif_stream_framer
  import jfpjc_pkg::*;
#(
  parameter  int WORD_BYTES = 4,
  parameter  int HEADER_LEN = 328,
  parameter  int COUNT_W    = 32,
  localparam int AW         = addr_w(HEADER_LEN),
  localparam int LBW        = $clog2(WORD_BYTES + 1),
  localparam int DW         = 8 * WORD_BYTES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hdr_wr_en,
  input  logic [AW-1:0]      hdr_wr_addr,
  input  logic [7:0]         hdr_wr_data,
  input  logic               stuff_en,
  input  logic               frame_start,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [LBW-1:0]     in_last_bytes,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [COUNT_W-1:0] frame_bytes
);

  localparam logic [AW-1:0] HDR_LAST = AW'(HEADER_LEN - 1);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_out_data, w_out_data_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [AW-1:0]      r_hdr_idx, w_hdr_idx_nxt;
  logic               r_hdr_done, w_hdr_done_nxt;
  logic [DW-1:0]      r_word, w_word_nxt;
  logic               r_word_valid, w_word_valid_nxt;
  logic [LBW-1:0]     r_left, w_left_nxt;
  logic               r_word_last, w_word_last_nxt;
  logic               r_stuff_pend, w_stuff_pend_nxt;
  logic               r_stuff_en, w_stuff_en_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic [COUNT_W-1:0] r_frame_bytes;

  logic               w_idle, w_hs, w_out_free, w_ff_stuff, w_in_ready;
  logic [AW-1:0]      w_rd_addr;
  logic [7:0]         w_ram_q;
  logic [DW-1:0]      w_word_shift;
  logic [LBW-1:0]     w_first_left;

  // The frame_done cycle still counts as busy, so it is not idle yet.
  assign w_idle       = (r_state == S_IDLE) && !r_frame_done;
  assign w_hs         = r_out_valid && out_ready;
  assign w_out_free   = !r_out_valid || out_ready;
  // The byte on the output is a data 0xFF that still owes its 0x00.
  assign w_ff_stuff   = r_stuff_en && !r_stuff_pend && (r_out_data == MARKER_PREFIX);
  // The word register keeps the current byte in its top lane.
  assign w_word_shift = r_word << 8;
  assign w_first_left = (in_last && (in_last_bytes != '0)) ? in_last_bytes - LBW'(1)
                                                           : LBW'(WORD_BYTES - 1);
  // A new word may enter only as the previous one's last byte leaves cleanly.
  assign w_in_ready   = (r_state == S_DATA) &&
                        (!r_word_valid ||
                         ((r_left == '0) && out_ready && !r_stuff_pend &&
                          !w_ff_stuff && !r_word_last));

  jfif_header_ram #(
    .DEPTH (HEADER_LEN),
    .AW    (AW)
  ) u_hdr_ram (
    .clock   (clock),
    .i_we    (hdr_wr_en && w_idle),
    .i_waddr (hdr_wr_addr),
    .i_wdata (hdr_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Next-state and datapath decisions for every state.
  always_comb begin
    w_state_nxt      = r_state;
    w_out_data_nxt   = r_out_data;
    w_out_valid_nxt  = r_out_valid;
    w_hdr_idx_nxt    = r_hdr_idx;
    w_hdr_done_nxt   = r_hdr_done;
    w_word_nxt       = r_word;
    w_word_valid_nxt = r_word_valid;
    w_left_nxt       = r_left;
    w_word_last_nxt  = r_word_last;
    w_stuff_pend_nxt = r_stuff_pend;
    w_stuff_en_nxt   = r_stuff_en;
    w_frame_done_nxt = 1'b0;
    w_rd_addr        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_idle && frame_start) begin
          w_state_nxt      = S_HEADER;
          w_stuff_en_nxt   = stuff_en;
          w_hdr_idx_nxt    = '0;
          w_hdr_done_nxt   = 1'b0;
          w_word_valid_nxt = 1'b0;
          w_stuff_pend_nxt = 1'b0;
        end
      end
      S_HEADER: begin
        if (r_hdr_done) begin
          if (w_hs) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_DATA;
          end
        end else if (w_out_free) begin
          w_out_data_nxt  = w_ram_q;
          w_out_valid_nxt = 1'b1;
          if (r_hdr_idx == HDR_LAST) w_hdr_done_nxt = 1'b1;
          else                       w_hdr_idx_nxt  = r_hdr_idx + AW'(1);
        end
        // Prefetch whichever byte will be loaded next cycle.
        w_rd_addr = w_hdr_idx_nxt;
      end
      S_DATA: begin
        if (r_word_valid && w_hs) begin
          w_stuff_pend_nxt = 1'b0;
          if (w_ff_stuff) begin
            w_out_data_nxt   = STUFF;
            w_stuff_pend_nxt = 1'b1;
          end else if (r_left != '0) begin
            w_word_nxt     = w_word_shift;
            w_out_data_nxt = w_word_shift[DW-1 -: 8];
            w_left_nxt     = r_left - LBW'(1);
          end else begin
            w_word_valid_nxt = 1'b0;
            w_out_valid_nxt  = 1'b0;
            if (r_word_last) begin
              w_state_nxt     = S_EOI_FF;
              w_out_data_nxt  = MARKER_PREFIX;
              w_out_valid_nxt = 1'b1;
            end
          end
        end
        if (w_in_ready && in_valid) begin
          w_word_nxt       = in_data;
          w_word_valid_nxt = 1'b1;
          w_left_nxt       = w_first_left;
          w_word_last_nxt  = in_last;
          w_out_data_nxt   = in_data[DW-1 -: 8];
          w_out_valid_nxt  = 1'b1;
        end
      end
      S_EOI_FF: begin
        if (w_hs) begin
          w_out_data_nxt = EOI;
          w_state_nxt    = S_EOI_D9;
        end
      end
      S_EOI_D9: begin
        if (w_hs) begin
          w_out_valid_nxt  = 1'b0;
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath registers and the frame byte counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_hdr_idx     <= '0;
      r_hdr_done    <= 1'b0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_left        <= '0;
      r_word_last   <= 1'b0;
      r_stuff_pend  <= 1'b0;
      r_stuff_en    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_bytes <= '0;
    end else begin
      r_out_data    <= w_out_data_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_hdr_idx     <= w_hdr_idx_nxt;
      r_hdr_done    <= w_hdr_done_nxt;
      r_word        <= w_word_nxt;
      r_word_valid  <= w_word_valid_nxt;
      r_left        <= w_left_nxt;
      r_word_last   <= w_word_last_nxt;
      r_stuff_pend  <= w_stuff_pend_nxt;
      r_stuff_en    <= w_stuff_en_nxt;
      r_frame_done  <= w_frame_done_nxt;
      if (w_idle && frame_start) r_frame_bytes <= '0;
      else if (w_hs)             r_frame_bytes <= r_frame_bytes + COUNT_W'(1);
    end
  end

  assign in_ready    = w_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != S_IDLE) || r_frame_done;
  assign frame_done  = r_frame_done;
  assign frame_bytes = r_frame_bytes;

endmodule

// File: tb/tb_jfif_stream_framer.sv
// Directed + randomized bench for jfif_stream_framer (4-byte words, 4-byte header).
module tb_jfif_stream_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hdr_wr_en = 1'b0;
  logic [1:0]  hdr_wr_addr = '0;
  logic [7:0]  hdr_wr_data = '0;
  logic        stuff_en = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  in_last_bytes = 3'd4;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic [31:0] frame_bytes;

  int total = 0;
  int bad   = 0;

  logic [7:0]  hdr_model [4];
  logic [31:0] wd [$];
  int          wlb [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  got [$];
  logic [7:0]  ref_q [$];
  int          acc_cyc [$];
  int          last_gaps;

  jfif_stream_framer #(
    .WORD_BYTES (4),
    .HEADER_LEN (4),
    .COUNT_W    (32)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .hdr_wr_en     (hdr_wr_en),
    .hdr_wr_addr   (hdr_wr_addr),
    .hdr_wr_data   (hdr_wr_data),
    .stuff_en      (stuff_en),
    .frame_start   (frame_start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_last_bytes (in_last_bytes),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_bytes   (frame_bytes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic write_hdr(input int addr, input logic [7:0] val);
    @(posedge clk); #1;
    hdr_wr_en = 1'b1; hdr_wr_addr = 2'(addr); hdr_wr_data = val;
    @(posedge clk); #1;
    hdr_wr_en = 1'b0;
    hdr_model[addr] = val;
  endtask

  // Expected stream straight from the framing rules.
  function automatic void build_exp(input bit stuff);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(hdr_model[i]);
    for (int w = 0; w < wd.size(); w++) begin
      int n;
      n = (w == wd.size() - 1) ? wlb[w] : 4;
      for (int b = 0; b < n; b++) begin
        logic [7:0] by;
        by = 8'(wd[w] >> (8 * (3 - b)));
        exp_q.push_back(by);
        if (stuff && by == 8'hFF) exp_q.push_back(8'h00);
      end
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_ff);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      logic [7:0] x;
      x = 8'($urandom);
      if (allow_ff && $urandom_range(3) == 0) x = 8'hFF;
      else if (!allow_ff && x == 8'hFF) x = 8'hFE;
      w[8*b +: 8] = x;
    end
    return w;
  endfunction

  task automatic drive_word(input int wi);
    in_valid      = (wi < wd.size());
    in_data       = (wi < wd.size()) ? wd[wi] : 32'h0;
    in_last       = (wi == wd.size() - 1);
    in_last_bytes = (wi == wd.size() - 1) ? 3'(wlb[wi]) : 3'd1;
  endtask

  // One complete frame; collects handshaked bytes and checks against the model.
  task automatic run_frame(input string name, input bit stuff, input int ready_pct, input bit poke);
    int wi = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit seen_v = 0;
    bit pv = 0;
    bit pr = 0;
    logic [7:0] pd = '0;
    got.delete();
    acc_cyc.delete();
    last_gaps = 0;
    build_exp(stuff);
    @(posedge clk); #1;
    frame_start = 1'b1; stuff_en = stuff; out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0; stuff_en = ~stuff;
    drive_word(wi);
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      if (cyc == 0) check({name, " lat0_valid"}, out_valid, 0);
      if (cyc == 1) check({name, " lat1_valid"}, out_valid, 1);
      if (pv && !pr) begin
        check({name, " stall_valid"}, out_valid, 1);
        check({name, " stall_data"}, out_data, pd);
      end
      if (frame_done) begin
        done_cnt++;
        check({name, " busy_at_done"}, busy, 1);
      end else begin
        if (out_valid && out_ready) got.push_back(out_data);
        if (out_valid) seen_v = 1;
        else if (seen_v) last_gaps++;
        if (in_valid && in_ready) begin
          acc_cyc.push_back(cyc);
          wi++;
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      @(posedge clk); #1;
      out_ready   = ($urandom_range(99) < 32'(ready_pct));
      frame_start = poke && (cyc == 2);
      hdr_wr_en   = poke && (cyc == 2);
      hdr_wr_addr = 2'd0;
      hdr_wr_data = 8'h55;
      drive_word(wi);
      cyc++;
    end
    frame_start = 1'b0; hdr_wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check({name, " done_seen"}, done_cnt, 1);
    @(negedge clk);
    check({name, " done_once"}, frame_done, 0);
    check({name, " busy_after"}, busy, 0);
    check({name, " len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s byte%0d", name, i), got[i], exp_q[i]);
    check({name, " frame_bytes"}, frame_bytes, exp_q.size());
    $display("frame %s: %0d bytes, %0d words accepted", name, got.size(), acc_cyc.size());
  endtask

  initial begin
    int n;
    bit same;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst frame_bytes", frame_bytes, 0);
    @(posedge clk); #1 reset = 1'b0;

    write_hdr(0, 8'hFF); write_hdr(1, 8'hD8); write_hdr(2, 8'hFF); write_hdr(3, 8'hE0);

    // Basic frame.
    wd = '{32'h12345678}; wlb = '{4};
    run_frame("basic", 1'b1, 100, 1'b0);

    // Stuffing on and off for an 0xFF-heavy word.
    wd = '{32'hFFAAFFFF}; wlb = '{4};
    run_frame("stuff_on", 1'b1, 100, 1'b0);
    check("stuff_on data_len", got.size(), 4 + 7 + 2);
    run_frame("stuff_off", 1'b0, 100, 1'b0);

    // Partial final word with a stuffed 0xFF at its last kept lane.
    wd = '{32'hABCDFFEE}; wlb = '{3};
    run_frame("partial", 1'b1, 100, 1'b0);

    // 100 random words at full rate, then with random backpressure.
    wd.delete(); wlb.delete();
    for (int i = 0; i < 100; i++) begin
      wd.push_back(rand_word(1'b1));
      wlb.push_back((i == 99) ? int'($urandom_range(4, 1)) : 4);
    end
    run_frame("rand_full", 1'b1, 100, 1'b0);
    ref_q = got;
    run_frame("rand_bp", 1'b1, 50, 1'b0);
    same = (got.size() == ref_q.size());
    for (int i = 0; i < got.size() && i < ref_q.size(); i++)
      if (got[i] != ref_q[i]) same = 0;
    check("rand_bp same_as_full", same, 1);

    // Three clean words: one acceptance every 4 cycles, no data gaps.
    wd.delete(); wlb.delete();
    for (int i = 0; i < 3; i++) begin
      wd.push_back(rand_word(1'b0));
      wlb.push_back(4);
    end
    run_frame("burst", 1'b1, 100, 1'b0);
    check("burst acc_count", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check("burst gap01", acc_cyc[1] - acc_cyc[0], 4);
      check("burst gap12", acc_cyc[2] - acc_cyc[1], 4);
    end
    check("burst out_gaps", last_gaps, 1);

    // Reset during a DATA stall.
    wd = '{32'h11223344, 32'h55667788}; wlb = '{4, 4};
    @(posedge clk); #1;
    frame_start = 1'b1; stuff_en = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    drive_word(0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      n++;
    end
    check("rstmid reached_data", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_word(1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rstmid stalled_data", out_data, 8'h11);
    @(negedge clk);
    check("rstmid out_valid", out_valid, 0);
    check("rstmid busy", busy, 0);
    check("rstmid in_ready", in_ready, 0);
    check("rstmid frame_bytes", frame_bytes, 0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Clean frame afterwards, with frame_start and a header write poked while busy.
    wd = '{32'h12345678}; wlb = '{4};
    run_frame("after_rst", 1'b1, 100, 1'b1);
    check("after_rst frame_bytes10", frame_bytes, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
